// File: rtl/spi_att_slave.sv
// SPI receiver that assembles N_PACKETS chip-select packets of N_BITS each
// into one word; malformed packets are flagged and drop the partial word.
module spi_att_slave #(
  parameter int N_BITS      = 8,
  parameter int N_PACKETS   = 1,
  parameter int SYNC_STAGES = 2,
  localparam int W = N_BITS * N_PACKETS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         spi_clk,
  input  logic         spi_ncs,
  input  logic         spi_mosi,
  output logic [W-1:0] data_out,
  output logic         data_valid,
  output logic         frame_err,
  output logic         busy,
  output logic [7:0]   pkt_idx
);

  localparam int CW = $clog2(N_BITS + 2);
  localparam int AW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] clk_sr, ncs_sr, mosi_sr;
  logic          clk_s, ncs_s, mosi_s;
  logic          clk_q, ncs_q;
  logic [AW-1:0] arm_cnt;
  logic          armed, sclk_edge, fall, rise;
  logic [CW-1:0] cnt, cnt_inc;
  logic [N_BITS-1:0] pkt, pkt_sh;
  logic [W-1:0]  asm_q, asm_n;
  logic          ld_first, shift_en, check;
  logic          good, last;

  assign clk_s  = clk_sr[SYNC_STAGES-1];
  assign ncs_s  = ncs_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  // The synchronizers reset high, so ignore ncs until they have flushed
  // in real pin state; otherwise a held-low ncs looks like a new frame.
  assign armed = (arm_cnt == AW'(SYNC_STAGES + 1));

  assign sclk_edge = clk_s & ~clk_q & ~ncs_s;
  assign fall      = armed & ncs_q & ~ncs_s;
  assign rise      = ~ncs_q & ncs_s;
  assign busy      = ~ncs_s;

  assign pkt_sh  = N_BITS'({pkt, mosi_s});
  assign cnt_inc = (cnt == CW'(N_BITS + 1)) ? cnt : cnt + CW'(1);
  assign good    = (cnt == CW'(N_BITS));
  assign last    = (pkt_idx == 8'(N_PACKETS - 1));

  always_comb begin
    asm_n = asm_q;
    for (int p = 0; p < N_PACKETS; p++) begin
      if (pkt_idx == 8'(p)) asm_n[W-1-p*N_BITS -: N_BITS] = pkt;
    end
  end

  always_comb begin
    state_n  = state;
    ld_first = 1'b0;
    shift_en = 1'b0;
    check    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          ld_first = 1'b1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = sclk_edge;
        if (rise) state_n = CHECK;
      end
      CHECK: begin
        check   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sr     <= '1;
      ncs_sr     <= '1;
      mosi_sr    <= '1;
      clk_q      <= 1'b1;
      ncs_q      <= 1'b1;
      arm_cnt    <= '0;
      state      <= IDLE;
      cnt        <= '0;
      pkt        <= '0;
      asm_q      <= '0;
      data_out   <= '0;
      pkt_idx    <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_sr     <= {clk_sr[SYNC_STAGES-2:0], spi_clk};
      ncs_sr     <= {ncs_sr[SYNC_STAGES-2:0], spi_ncs};
      mosi_sr    <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      clk_q      <= clk_s;
      ncs_q      <= ncs_s;
      state      <= state_n;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!armed) arm_cnt <= arm_cnt + AW'(1);
      if (ld_first) begin
        cnt <= sclk_edge ? CW'(1) : '0;
        if (sclk_edge) pkt <= pkt_sh;
      end
      if (shift_en) begin
        cnt <= cnt_inc;
        pkt <= pkt_sh;
      end
      if (check) begin
        if (good) begin
          asm_q <= asm_n;
          if (last) begin
            data_out   <= asm_n;
            data_valid <= 1'b1;
            pkt_idx    <= '0;
          end else begin
            pkt_idx <= pkt_idx + 8'd1;
          end
        end else begin
          frame_err <= 1'b1;
          pkt_idx   <= '0;
          asm_q     <= '0;
        end
      end
    end
  end

endmodule
